// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, captures the fetched word with PC+step
// into the IF/ID register, and handles stall, branch redirect, flush and HALT.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_addr_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        halt_i,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_p0, state_n;
    logic [31:0] pc_p0, pc_n;
    logic [31:0] ifid_instr_p1, instr_n;
    logic [31:0] ifid_pc4_p1, pc4_n;
    logic        vld_p1, vld_n;
    logic [31:0] fetch_cnt_p1, cnt_n;
    logic [31:0] pc_seq;

    // Sequential fetch address; 32-bit arithmetic wraps FFFF_FFFC -> 0 naturally.
    assign pc_seq = pc_p0 + STEP;

    // Next-state logic: HALT dominates, then branch, flush, stall, then normal fetch.
    always_comb begin
        state_n = state_p0;
        pc_n    = pc_p0;
        instr_n = ifid_instr_p1;
        pc4_n   = ifid_pc4_p1;
        vld_n   = vld_p1;
        cnt_n   = fetch_cnt_p1;

        if (state_p0 == HALT || halt_i) begin
            state_n = HALT;
            instr_n = NOP_WORD;
            pc4_n   = 32'h0;
            vld_n   = 1'b0;
        end else begin
            // Branch redirect wins over stall: the target must not be lost.
            if (branch_i) begin
                pc_n = {branch_target_i[31:2], 2'b00};
            end else if (!stall_i) begin
                pc_n = pc_seq;
            end

            // Wrong-path or squashed word becomes a bubble.
            if (flush_i || branch_i) begin
                instr_n = NOP_WORD;
                pc4_n   = 32'h0;
                vld_n   = 1'b0;
            end else if (!stall_i) begin
                instr_n = instr_i;
                pc4_n   = pc_seq;
                vld_n   = 1'b1;
                cnt_n   = fetch_cnt_p1 + 32'd1;
            end
        end
    end

    // Fetch / IF-ID stage boundary registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_p0      <= RUN;
            pc_p0         <= RESET_PC;
            ifid_instr_p1 <= NOP_WORD;
            ifid_pc4_p1   <= 32'h0;
            vld_p1        <= 1'b0;
            fetch_cnt_p1  <= 32'h0;
        end else begin
            state_p0      <= state_n;
            pc_p0         <= pc_n;
            ifid_instr_p1 <= instr_n;
            ifid_pc4_p1   <= pc4_n;
            vld_p1        <= vld_n;
            fetch_cnt_p1  <= cnt_n;
        end
    end

    assign pc_addr_o    = pc_p0;
    assign ifid_instr_o = ifid_instr_p1;
    assign ifid_pc4_o   = ifid_pc4_p1;
    assign ifid_valid_o = vld_p1;
    assign halted_o     = (state_p0 == HALT);
    assign fetch_cnt_o  = fetch_cnt_p1;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written reset/wrap sequences,
// and randomized traffic against a rule-level reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic [31:0] instr;
    logic        stall, flush, branch, halt;
    logic [31:0] tgt;
    logic [31:0] ifid_pc4, ifid_instr, fetch_cnt;
    logic        ifid_valid, halted;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pc_addr_o      (pc_addr),
        .instr_i        (instr),
        .stall_i        (stall),
        .flush_i        (flush),
        .branch_i       (branch),
        .branch_target_i(tgt),
        .halt_i         (halt),
        .ifid_pc4_o     (ifid_pc4),
        .ifid_instr_o   (ifid_instr),
        .ifid_valid_o   (ifid_valid),
        .halted_o       (halted),
        .fetch_cnt_o    (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'd3) + 32'h1357_0001;
    endfunction

    // Combinational instruction memory.
    always_comb instr = word_at(pc_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_vld, input logic e_halt,
                             input logic [31:0] e_cnt);
        check({tag, ".pc"},     pc_addr,           e_pc);
        check({tag, ".instr"},  ifid_instr,        e_instr);
        check({tag, ".pc4"},    ifid_pc4,          e_pc4);
        check({tag, ".valid"},  {31'h0, ifid_valid}, {31'h0, e_vld});
        check({tag, ".halted"}, {31'h0, halted},     {31'h0, e_halt});
        check({tag, ".cnt"},    fetch_cnt,         e_cnt);
    endtask

    task automatic set_in(input logic s, input logic f, input logic b, input logic h, input logic [31:0] t);
        stall = s; flush = f; branch = b; halt = h; tgt = t;
    endtask

    // Reset pulse placed away from the clock edge.
    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        stall, flush, branch, halt;
        logic [31:0] tgt;
        logic [31:0] pc, instr, pc4;
        logic        valid, halted;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[13];

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_halt;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] nxt;
        if (m_halt || halt) begin
            m_halt = 1'b1;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            if (branch)      nxt = tgt & 32'hFFFF_FFFC;
            else if (stall)  nxt = m_pc;
            else             nxt = m_pc + 32'd4;
            if (flush || branch) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = word_at(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            m_pc = nxt;
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'd4,  word_at(32'd0),  32'd4,  1'b1,1'b0, 32'd1};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'd8,  word_at(32'd4),  32'd8,  1'b1,1'b0, 32'd2};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   32'd8,  word_at(32'd4),  32'd8,  1'b1,1'b0, 32'd2};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 32'h0,   32'd8,  word_at(32'd4),  32'd8,  1'b1,1'b0, 32'd2};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'd12, word_at(32'd8),  32'd12, 1'b1,1'b0, 32'd3};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'd16, word_at(32'd12), 32'd16, 1'b1,1'b0, 32'd4};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'd20, word_at(32'd16), 32'd20, 1'b1,1'b0, 32'd5};
        vecs[7]  = '{1'b0,1'b1,1'b0,1'b0, 32'h0,   32'd24, 32'h0,           32'd0,  1'b0,1'b0, 32'd5};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'd28, word_at(32'd24), 32'd28, 1'b1,1'b0, 32'd6};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0, 32'h43,  32'h40, 32'h0,           32'd0,  1'b0,1'b0, 32'd6};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b1, 32'h100, 32'h40, 32'h0,           32'd0,  1'b0,1'b1, 32'd6};
        vecs[11] = '{1'b1,1'b1,1'b1,1'b0, 32'h200, 32'h40, 32'h0,           32'd0,  1'b0,1'b1, 32'd6};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h40, 32'h0,           32'd0,  1'b0,1'b1, 32'd6};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #12;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].stall, vecs[i].flush, vecs[i].branch, vecs[i].halt, vecs[i].tgt);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                      vecs[i].valid, vecs[i].halted, vecs[i].cnt);
        end

        // Asynchronous reset in the middle of a stall at the top of the address space.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        check_all("rst_exit_halt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("top.pc", pc_addr, 32'hFFFF_FFFC);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check("top_stall.pc", pc_addr, 32'hFFFF_FFFC);
        #2;
        rst = 1'b1;
        #1;
        check_all("midcycle_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        rst = 1'b0;

        // Free-run wrap from FFFF_FFFC to 0.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        check_all("wrap", 32'h0, word_at(32'hFFFF_FFFC), 32'h0, 1'b1, 1'b0, 32'd1);
        @(posedge clk); #1;
        check_all("wrap2", 32'h4, word_at(32'h0), 32'h4, 1'b1, 1'b0, 32'd2);

        // Randomized traffic against the reference model, with periodic resets.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 97 == 96) begin
                set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
                pulse_reset();
                model_reset();
                check_all("rnd_rst", m_pc, m_instr, m_pc4, m_valid, m_halt, m_cnt);
            end
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            branch = ($urandom_range(0, 7) == 0);
            halt   = ($urandom_range(0, 59) == 0);
            tgt    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom;
            model_edge();
            @(posedge clk); #1;
            check_all("rnd", m_pc, m_instr, m_pc4, m_valid, m_halt, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
